wb_commit_unit: RTL and testbench
=================================

Name: wb_commit_unit

Overview:
- Consumer end of the MEM/WB interface: takes the WB-stage bundle and selects the writeback value.
- Commits that value into the 32x32 integer register file and serves the two ID-stage read ports, with write-to-read bypass.
- Maintains a 64-bit retired-instruction counter.
- Sits between the MEM/WB pipeline register and the decode stage of the 5-stage SCPU.

Parameters:
- XLEN, 32, datapath width.
- NREGS, 32, architectural registers; x0 is hardwired to zero.
- CNT_W, 64, retired-instruction counter width.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wb_ctrl  in  3  bit0 reg_write; bits[2:1] wb_sel: 00 alu_result, 01 data_in, 10 pc_out, 11 imm.
- wb_data_in  in  32  load data from MEM.
- wb_alu_result  in  32  ALU result.
- wb_imm  in  32  immediate (LUI).
- wb_pc_out  in  32  link value (PC+4).
- wb_rd_addr  in  5  destination register.
- wb_pc_addr0  in  32  PC of the committing instruction.
- wb_inst  in  32  committing instruction word.
- rs1_addr  in  5  ID read port 1 address.
- rs2_addr  in  5  ID read port 2 address.
- rs1_data  out  32  read port 1 data.
- rs2_data  out  32  read port 2 data.
- wb_write_data  out  32  selected writeback value (forwarding source).
- wb_write_en  out  1  effective write enable (reg_write and rd != 0).
- instret  out  64  retired-instruction count.

Behaviour:
- Reset: asynchronous, active-high.
  - All registers x1..x31 clear to 0 immediately on rst rising; instret clears to 0.
  - With rst held, rs1_data/rs2_data read 0 and no writes occur.
  - wb_write_data and wb_write_en are combinational; with the reset-state MEM/WB bundle (ctrl 000, inst 0x00000013) they are 0.
- Writeback value: wb_write_data = mux(wb_sel) over {alu_result, data_in, pc_out, imm}. This output is purely combinational, with zero latency.
- Write: on a rising clk with wb_write_en=1, regs[wb_rd_addr] <= wb_write_data. Writes to rd=0 are discarded; x0 always reads 0.
- Read: combinational.
  - rsN_data = 0 if rsN_addr==0.
  - Else, if wb_write_en and rsN_addr==wb_rd_addr, the output is wb_write_data (same-cycle bypass; WB write precedes ID read).
  - Else the output is regs[rsN_addr].
  - Both ports may hit the bypass simultaneously.
- Retire counting: instret increments by 1 on each clk edge unless wb_inst==32'h00000013 AND wb_ctrl==3'b000.
  - That pair is the canonical bubble injected by reset/flush and is not counted.
  - A real NOP still counts only if it carries a nonzero ctrl; a bubble never does.
  - The counter wraps modulo 2^64 silently.
- Reset mid-operation aborts any in-flight write: no partial update, and the counter is zero on the following cycle.
- No stall input: MEM/WB is always valid, and bubbles are represented in-band.

Optional Feature:
- Macro WB_TRACE_EN.
- Defined: adds outputs trace_valid(1), trace_pc(32), trace_inst(32), trace_rd(5), trace_wdata(32), trace_we(1).
  - These are registered, one cycle after the commit edge.
  - trace_valid follows the instret increment condition.
  - All trace outputs reset to 0.
- Undefined: these ports and flops do not exist; core behaviour is identical.

Decomposition:
- Shared package scpu_wb_pkg holds:
  - WB_SEL_ALU=2'b00, WB_SEL_MEM=2'b01, WB_SEL_PC4=2'b10, WB_SEL_IMM=2'b11;
  - WB_CTRL_REGWRITE bit index 0;
  - NOP_INST=32'h00000013;
  - XLEN and NREGS.
- One sub-module, regfile_2r1w: storage, x0 masking and bypass.
- The top level holds the writeback mux, the retire counter and the trace logic.

Test Plan:
- Reset: assert rst asynchronously mid-cycle after writing x5=0xDEADBEEF -> rs1_addr=5 reads 0 immediately, and instret=0.
- Select: ctrl=3'b011, alu=0x11, mem=0x22, pc_out=0x33, imm=0x44, rd=7 -> wb_write_data=0x22 and x7=0x22 after the edge. Repeat for ctrl 001/101/111 -> 0x11/0x33/0x44.
- x0: ctrl=3'b001, rd=0, alu=0xFFFFFFFF -> wb_write_en=0 and rs1_addr=0 reads 0.
- Bypass: same cycle ctrl=001, rd=9, alu=0xCAFE0001, rs1_addr=rs2_addr=9 -> both read 0xCAFE0001 before the edge; the old value is not visible.
- Counting: 4 bubbles (inst 0x13, ctrl 000), then 3 real commits, then 1 store (ctrl 000, inst 0x00A12023) -> instret=4. Separately, preload instret to 2^64-1 via forced stimulus, then commit once -> instret wraps to 0.
- Trace (WB_TRACE_EN): commit pc=0x100, inst=0x00500093, rd=1, data=5 -> next cycle trace_valid=1, trace_pc=0x100, trace_rd=1, trace_wdata=5, trace_we=1; a bubble gives trace_valid=0.

Source files
------------

// File: rtl/scpu_wb_pkg.sv
// Shared writeback-stage definitions for the SCPU: select encodings, control bit
// positions, the canonical bubble instruction and architectural sizes.
package scpu_wb_pkg;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int REG_AW = $clog2(NREGS);
    localparam int CTRL_W = 3;

    typedef enum logic [1:0] {
        WB_SEL_ALU = 2'b00,
        WB_SEL_MEM = 2'b01,
        WB_SEL_PC4 = 2'b10,
        WB_SEL_IMM = 2'b11
    } wb_sel_e;

    localparam int              WB_CTRL_REGWRITE = 0;
    localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;

    // Reset/flush inject exactly this pair; anything else is a real retirement.
    function automatic logic is_bubble(input logic [XLEN-1:0] inst,
                                       input logic [CTRL_W-1:0] ctrl);
        return (inst == NOP_INST) && (ctrl == '0);
    endfunction

endpackage

// File: rtl/wb_commit_unit_regfile_2r1w.sv
// 32x32 integer register file: one write port, two combinational read ports,
// x0 hardwired to zero and same-cycle write-to-read bypass.
module regfile_2r1w
    import scpu_wb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [REG_AW-1:0] raddr1_i,
    input  logic [REG_AW-1:0] raddr2_i,
    output logic [XLEN-1:0]   rdata1_o,
    output logic [XLEN-1:0]   rdata2_o
);

    logic [XLEN-1:0] regs_q [NREGS];

    // Entry 0 is cleared by reset and never written, so it stays a constant zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    logic [REG_AW-1:0] raddr [2];
    logic [XLEN-1:0]   rdata [2];

    assign raddr[0] = raddr1_i;
    assign raddr[1] = raddr2_i;

    // WB writes before ID reads, so a matching in-flight write wins over storage.
    // Reset forces zero so an in-flight bypass cannot leak while rst is held.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
            always_comb begin
                rdata[gi] = regs_q[raddr[gi]];
                if (rst || (raddr[gi] == '0)) begin
                    rdata[gi] = '0;
                end else if (we_i && (raddr[gi] == waddr_i)) begin
                    rdata[gi] = wdata_i;
                end
            end
        end
    endgenerate

    assign rdata1_o = rdata[0];
    assign rdata2_o = rdata[1];

endmodule

// File: rtl/wb_commit_unit.sv
// MEM/WB consumer: writeback select, register-file commit with ID read ports,
// and the retired-instruction counter. Define WB_TRACE_EN to add a commit trace port.
module wb_commit_unit
    import scpu_wb_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CTRL_W-1:0]   wb_ctrl,
    input  logic [XLEN-1:0]     wb_data_in,
    input  logic [XLEN-1:0]     wb_alu_result,
    input  logic [XLEN-1:0]     wb_imm,
    input  logic [XLEN-1:0]     wb_pc_out,
    input  logic [REG_AW-1:0]   wb_rd_addr,
    input  logic [XLEN-1:0]     wb_pc_addr0,
    input  logic [XLEN-1:0]     wb_inst,
    input  logic [REG_AW-1:0]   rs1_addr,
    input  logic [REG_AW-1:0]   rs2_addr,
    output logic [XLEN-1:0]     rs1_data,
    output logic [XLEN-1:0]     rs2_data,
    output logic [XLEN-1:0]     wb_write_data,
    output logic                wb_write_en,
    output logic [CNT_W-1:0]    instret
`ifdef WB_TRACE_EN
    ,
    output logic                trace_valid,
    output logic [XLEN-1:0]     trace_pc,
    output logic [XLEN-1:0]     trace_inst,
    output logic [REG_AW-1:0]   trace_rd,
    output logic [XLEN-1:0]     trace_wdata,
    output logic                trace_we
`endif
);

    wb_sel_e wb_sel;
    logic    retire;

    assign wb_sel = wb_sel_e'(wb_ctrl[2:1]);

    always_comb begin
        wb_write_data = wb_alu_result;
        unique case (wb_sel)
            WB_SEL_ALU: wb_write_data = wb_alu_result;
            WB_SEL_MEM: wb_write_data = wb_data_in;
            WB_SEL_PC4: wb_write_data = wb_pc_out;
            WB_SEL_IMM: wb_write_data = wb_imm;
            default:    wb_write_data = wb_alu_result;
        endcase
    end

    assign wb_write_en = wb_ctrl[WB_CTRL_REGWRITE] && (wb_rd_addr != '0);
    assign retire      = !is_bubble(wb_inst, wb_ctrl);

    regfile_2r1w u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we_i     (wb_write_en),
        .waddr_i  (wb_rd_addr),
        .wdata_i  (wb_write_data),
        .raddr1_i (rs1_addr),
        .raddr2_i (rs2_addr),
        .rdata1_o (rs1_data),
        .rdata2_o (rs2_data)
    );

    // Wraps silently at 2^CNT_W.
    logic [CNT_W-1:0] instret_q;
    logic [CNT_W-1:0] instret_d;

    always_comb begin
        instret_d = instret_q;
        if (retire) begin
            instret_d = instret_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;

`ifdef WB_TRACE_EN
    logic              trace_valid_q;
    logic [XLEN-1:0]   trace_pc_q;
    logic [XLEN-1:0]   trace_inst_q;
    logic [REG_AW-1:0] trace_rd_q;
    logic [XLEN-1:0]   trace_wdata_q;
    logic              trace_we_q;

    // Snapshot of what committed on the previous edge; valid tracks the retire rule.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trace_valid_q <= 1'b0;
            trace_pc_q    <= '0;
            trace_inst_q  <= '0;
            trace_rd_q    <= '0;
            trace_wdata_q <= '0;
            trace_we_q    <= 1'b0;
        end else begin
            trace_valid_q <= retire;
            trace_pc_q    <= wb_pc_addr0;
            trace_inst_q  <= wb_inst;
            trace_rd_q    <= wb_rd_addr;
            trace_wdata_q <= wb_write_data;
            trace_we_q    <= wb_write_en;
        end
    end

    assign trace_valid = trace_valid_q;
    assign trace_pc    = trace_pc_q;
    assign trace_inst  = trace_inst_q;
    assign trace_rd    = trace_rd_q;
    assign trace_wdata = trace_wdata_q;
    assign trace_we    = trace_we_q;
`else
    logic unused_trace_pc;
    assign unused_trace_pc = ^wb_pc_addr0;
`endif

endmodule

// File: tb/tb_wb_commit_unit.sv
// Randomized self-checking bench for wb_commit_unit against a register-array
// and counter reference model; covers trace outputs when WB_TRACE_EN is defined.
module tb_wb_commit_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  wb_ctrl;
    logic [31:0] wb_data_in, wb_alu_result, wb_imm, wb_pc_out, wb_pc_addr0, wb_inst;
    logic [4:0]  wb_rd_addr, rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data, wb_write_data;
    logic        wb_write_en;
    logic [63:0] instret;
`ifdef WB_TRACE_EN
    logic        trace_valid, trace_we;
    logic [31:0] trace_pc, trace_inst, trace_wdata;
    logic [4:0]  trace_rd;
`endif

    always #5 clk = ~clk;

    wb_commit_unit dut (
        .clk           (clk),
        .rst           (rst),
        .wb_ctrl       (wb_ctrl),
        .wb_data_in    (wb_data_in),
        .wb_alu_result (wb_alu_result),
        .wb_imm        (wb_imm),
        .wb_pc_out     (wb_pc_out),
        .wb_rd_addr    (wb_rd_addr),
        .wb_pc_addr0   (wb_pc_addr0),
        .wb_inst       (wb_inst),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .wb_write_data (wb_write_data),
        .wb_write_en   (wb_write_en),
        .instret       (instret)
`ifdef WB_TRACE_EN
        ,
        .trace_valid   (trace_valid),
        .trace_pc      (trace_pc),
        .trace_inst    (trace_inst),
        .trace_rd      (trace_rd),
        .trace_wdata   (trace_wdata),
        .trace_we      (trace_we)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] m_regs [32];
    logic [63:0] m_cnt;
    logic        m_tv, m_twe;
    logic [31:0] m_tpc, m_tinst, m_twd;
    logic [4:0]  m_trd;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_wdata();
        case (wb_ctrl[2:1])
            2'b00:   return wb_alu_result;
            2'b01:   return wb_data_in;
            2'b10:   return wb_pc_out;
            default: return wb_imm;
        endcase
    endfunction

    function automatic logic m_we();
        return wb_ctrl[0] && (wb_rd_addr != 5'd0);
    endfunction

    function automatic logic m_counts();
        return !((wb_inst == 32'h0000_0013) && (wb_ctrl == 3'b000));
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (m_we() && (a == wb_rd_addr)) return m_wdata();
        return m_regs[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_cnt = 64'd0;
    endtask

    task automatic drive(input logic [2:0] ctrl, input logic [31:0] alu, input logic [31:0] mem,
                         input logic [31:0] pc4, input logic [31:0] imm, input logic [4:0] rd,
                         input logic [31:0] inst, input logic [31:0] pc,
                         input logic [4:0] a1, input logic [4:0] a2);
        wb_ctrl = ctrl; wb_alu_result = alu; wb_data_in = mem; wb_pc_out = pc4;
        wb_imm = imm; wb_rd_addr = rd; wb_inst = inst; wb_pc_addr0 = pc;
        rs1_addr = a1; rs2_addr = a2;
        #1;
    endtask

    task automatic bubble(input logic [4:0] a1, input logic [4:0] a2);
        drive(3'b000, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 32'h0000_0013, 32'd0, a1, a2);
    endtask

    task automatic check_comb(input string tag);
        check_eq({tag, "_wdata"}, {32'd0, wb_write_data}, {32'd0, m_wdata()});
        check_eq({tag, "_we"},    {63'd0, wb_write_en},   {63'd0, m_we()});
        check_eq({tag, "_rs1"},   {32'd0, rs1_data},      {32'd0, m_read(rs1_addr)});
        check_eq({tag, "_rs2"},   {32'd0, rs2_data},      {32'd0, m_read(rs2_addr)});
    endtask

    // One commit edge: update the model from the bundle, then check the counter.
    task automatic tick(input string tag);
        @(posedge clk);
        m_tv = m_counts(); m_tpc = wb_pc_addr0; m_tinst = wb_inst;
        m_trd = wb_rd_addr; m_twd = m_wdata(); m_twe = m_we();
        if (m_we()) m_regs[wb_rd_addr] = m_wdata();
        if (m_counts()) m_cnt = m_cnt + 64'd1;
        $display("[TB] %s ctrl=%b rd=%0d wdata=%h inst=%h", tag, wb_ctrl, wb_rd_addr, m_twd, wb_inst);
        @(negedge clk);
        check_eq({tag, "_instret"}, instret, m_cnt);
`ifdef WB_TRACE_EN
        check_eq({tag, "_tvalid"}, {63'd0, trace_valid}, {63'd0, m_tv});
        check_eq({tag, "_tpc"},    {32'd0, trace_pc},    {32'd0, m_tpc});
        check_eq({tag, "_tinst"},  {32'd0, trace_inst},  {32'd0, m_tinst});
        check_eq({tag, "_trd"},    {59'd0, trace_rd},    {59'd0, m_trd});
        check_eq({tag, "_twdata"}, {32'd0, trace_wdata}, {32'd0, m_twd});
        check_eq({tag, "_twe"},    {63'd0, trace_we},    {63'd0, m_twe});
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  sel_ctrl [4];
        logic [31:0] sel_exp  [4];
        logic [4:0]  rd, a1, a2;
        sel_ctrl = '{3'b011, 3'b001, 3'b101, 3'b111};
        sel_exp  = '{32'h22, 32'h11, 32'h33, 32'h44};

        // Reset state
        rst = 1'b1;
        model_reset();
        bubble(5'd3, 5'd0);
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_rs1",     {32'd0, rs1_data},      64'd0);
        check_eq("rst_instret", instret,                64'd0);
        check_eq("rst_wdata",   {32'd0, wb_write_data}, 64'd0);
        check_eq("rst_we",      {63'd0, wb_write_en},   64'd0);
        rst = 1'b0;

        // Writeback select
        for (int i = 0; i < 4; i++) begin
            drive(sel_ctrl[i], 32'h11, 32'h22, 32'h33, 32'h44, 5'd7, 32'h0000_0033, 32'h40, 5'd7, 5'd0);
            check_eq("sel_wdata", {32'd0, wb_write_data}, {32'd0, sel_exp[i]});
            check_comb("sel");
            tick("sel");
            bubble(5'd7, 5'd7);
            check_eq("sel_x7", {32'd0, rs1_data}, {32'd0, sel_exp[i]});
        end

        // Write to x0 is discarded
        drive(3'b001, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 5'd0, 32'h0000_0033, 32'h44, 5'd0, 5'd0);
        check_eq("x0_we",  {63'd0, wb_write_en}, 64'd0);
        check_eq("x0_rs1", {32'd0, rs1_data},    64'd0);
        tick("x0");

        // Dual-port same-cycle bypass over an older value
        drive(3'b001, 32'h1234_5678, 32'd0, 32'd0, 32'd0, 5'd9, 32'h0000_0033, 32'h48, 5'd0, 5'd0);
        tick("byp_pre");
        drive(3'b001, 32'hCAFE_0001, 32'd0, 32'd0, 32'd0, 5'd9, 32'h0000_0033, 32'h4C, 5'd9, 5'd9);
        check_eq("byp_rs1", {32'd0, rs1_data}, 64'hCAFE_0001);
        check_eq("byp_rs2", {32'd0, rs2_data}, 64'hCAFE_0001);
        tick("byp");

        // Asynchronous reset mid-cycle, with a write in flight
        drive(3'b001, 32'hDEAD_BEEF, 32'd0, 32'd0, 32'd0, 5'd5, 32'h0000_0033, 32'h50, 5'd0, 5'd0);
        tick("x5");
        drive(3'b001, 32'h0000_0055, 32'd0, 32'd0, 32'd0, 5'd6, 32'h0000_0033, 32'h54, 5'd5, 5'd6);
        check_eq("pre_rst_x5", {32'd0, rs1_data}, 64'hDEAD_BEEF);
        #1 rst = 1'b1;
        #1;
        check_eq("arst_rs1",     {32'd0, rs1_data}, 64'd0);
        check_eq("arst_rs2",     {32'd0, rs2_data}, 64'd0);
        check_eq("arst_instret", instret,           64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        bubble(5'd6, 5'd5);
        check_eq("abort_x6",      {32'd0, rs1_data}, 64'd0);
        check_eq("abort_x5",      {32'd0, rs2_data}, 64'd0);
        check_eq("abort_instret", instret,           64'd0);

        // Bubbles are not counted; real commits and a store are
        for (int i = 0; i < 4; i++) begin
            bubble(5'd0, 5'd0);
            tick("cnt_bubble");
        end
        for (int i = 0; i < 3; i++) begin
            drive(3'b001, 32'(i + 1), 32'd0, 32'd0, 32'd0, 5'(i + 1), 32'h0000_0093, 32'(i * 4), 5'd0, 5'd0);
            tick("cnt_real");
        end
        drive(3'b000, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 32'h00A1_2023, 32'h0C, 5'd0, 5'd0);
        tick("cnt_store");
        check_eq("cnt_total", instret, 64'd4);

`ifdef WB_TRACE_EN
        drive(3'b001, 32'd5, 32'd0, 32'd0, 32'd0, 5'd1, 32'h0050_0093, 32'h100, 5'd0, 5'd0);
        tick("trace");
        check_eq("trace_valid", {63'd0, trace_valid}, 64'd1);
        check_eq("trace_pc",    {32'd0, trace_pc},    64'h100);
        check_eq("trace_rd",    {59'd0, trace_rd},    64'd1);
        check_eq("trace_wdata", {32'd0, trace_wdata}, 64'd5);
        check_eq("trace_we",    {63'd0, trace_we},    64'd1);
        bubble(5'd0, 5'd0);
        tick("trace_bub");
        check_eq("trace_bub_valid", {63'd0, trace_valid}, 64'd0);
`endif

        // Randomized traffic with biased address collisions
        for (int n = 0; n < 300; n++) begin
            rd = 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) begin
                bubble(a1, a2);
            end else begin
                drive(3'($urandom), $urandom, $urandom, $urandom, $urandom, rd,
                      ($urandom_range(0, 3) == 0) ? 32'h0000_0013 : $urandom, $urandom, a1, a2);
            end
            check_comb("rnd");
            tick("rnd");
        end

        // Counter wrap from all-ones
        bubble(5'd0, 5'd0);
        force dut.instret_q = {64{1'b1}};
        @(posedge clk);
        @(negedge clk);
        release dut.instret_q;
        m_cnt = {64{1'b1}};
        #1;
        check_eq("wrap_preload", instret, {64{1'b1}});
        drive(3'b001, 32'h77, 32'd0, 32'd0, 32'd0, 5'd3, 32'h0000_0093, 32'h200, 5'd0, 5'd0);
        tick("wrap");
        check_eq("wrap_zero", instret, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
